mips_if_stage: RTL and testbench
================================

MIPS_IF_STAGE -- requirements
Module: mips_if_stage

Interface
REQ-001 Parameter PM_DEPTH, default 1024, program memory depth in 32-bit words.
REQ-002 Parameter RESET_PC, default 0, word address fetched first after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall_i  input  1  hazard-unit hold (load-use): freeze PC and IF/ID.
REQ-006 redirect_i  input  1  taken branch from EX/MEM: flush and redirect.
REQ-007 redirect_pc_i  input  32  branch target word address.
REQ-008 pm_we_i  input  1  program-memory write enable.
REQ-009 pm_addr_i  input  10  program-memory write word address.
REQ-010 pm_wdata_i  input  32  program-memory write data.
REQ-011 pc_o  output  32  current fetch PC.
REQ-012 if_id_ir_o  output  32  IF/ID instruction register.
REQ-013 if_id_npc_o  output  32  IF/ID next-PC (fetch PC + 1).
REQ-014 if_id_valid_o  output  1  IF/ID holds a real instruction.
REQ-015 halted_o  output  1  fetch permanently stopped by HLT.

Function
REQ-016 PC is word-addressed: sequential fetch adds 1 per cycle; the memory index is PC modulo PM_DEPTH (wrap-around, no error).
REQ-017 Program memory read is combinational from the PC; an instruction appears on IF/ID at the edge after its PC is presented (latency 1).
REQ-018 A write occurs at the rising edge; a same-cycle fetch of the same address returns the old word.
REQ-019 Priority per edge: redirect_i > stall_i > normal fetch.
REQ-020 Redirect: PC <= redirect_pc_i; IR <= NOP (32'h00000000); valid <= 0; NPC <= 0; this also applies when stall_i is high.
REQ-021 Stall (no redirect): PC, IR, NPC, valid and FSM state hold unchanged.
REQ-022 Normal fetch: IR <= mem[PC]; NPC <= PC + 1; valid <= 1; PC <= PC + 1.
REQ-023 FSM states: RUN, HALT_PEND, HALTED.
REQ-024 RUN -> HALT_PEND when a normal fetch loads opcode IR[31:26] = 6'b111111 (HLT); PC is not incremented past the HLT.
REQ-025 In HALT_PEND the PC holds, the HLT word stays in IF/ID while stall_i is high, and no new word is fetched.
REQ-026 HALT_PEND -> RUN on redirect_i, because a branch-shadow HLT is squashed; the fetch resumes at redirect_pc_i.
REQ-027 HALT_PEND -> HALTED on the first edge with no stall and no redirect; IF/ID becomes NOP with valid = 0.
REQ-028 In HALTED, halted_o = 1, PC and IF/ID are frozen, and redirect_i and stall_i are ignored until reset.
REQ-029 halted_o is a registered output: it is 1 only in HALTED.

Reset
REQ-030 On reset low, immediately and independent of clk: pc_o = RESET_PC, if_id_ir_o = 0, if_id_npc_o = 0, if_id_valid_o = 0, halted_o = 0, FSM = RUN.
REQ-031 Reset mid-operation discards any pending HLT or redirect; program memory contents are not reset.
REQ-032 The first fetch occurs on the first rising edge after reset deasserts.

Structure
REQ-033 Shared package mips_pkg holds the opcode constants (ADD 6'h00, LW 6'h08, SW 6'h09, BNEQZ 6'h0D, BEQZ 6'h0E, HLT 6'h3F), the NOP word and the fetch-FSM state enum.
REQ-034 Program memory is one sub-module, mips_prog_mem, with one write port and one combinational read port.

Verification
REQ-035 Sequential fetch: load mem[0..2] = 20410000, 20830000, 00232800 and release reset -> IR sequence is 20410000, 20830000, 00232800; NPC is 1, 2, 3; valid = 1 from the first edge.
REQ-036 Load-use stall: assert stall_i for 1 cycle while IR = 00232800, PC = 3 -> IR, NPC and PC are unchanged for that edge, then fetch resumes at 3.
REQ-037 Redirect: with PC = 5, assert redirect_i with redirect_pc_i = 10 and mem[10] = 24E50000 -> next edge gives IR = 0, valid = 0, PC = 10; the following edge gives IR = 24E50000, NPC = 11.
REQ-038 Redirect during stall: stall_i = 1 and redirect_i = 1 together with target 10 -> PC = 10 and valid = 0, so the flush wins.
REQ-039 Squashed HLT: mem[5] = FC000000; fetch it, then assert redirect_i to 10 on the next edge -> FSM returns to RUN, halted_o stays 0 and fetch continues at 10.
REQ-040 Halt and reset: fetch FC000000 at PC 11 with no redirect -> halted_o = 1 two edges later and PC stays 11 for 20 cycles despite redirect pulses; asserting reset low mid-cycle clears halted_o and sets PC = 0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, the NOP word and the fetch-stage FSM states.
package mips_pkg;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ  = 6'h0E;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } fetch_state_e;

  function automatic logic is_hlt(input logic [31:0] word);
    return word[31:26] == OP_HLT;
  endfunction

endpackage

// File: rtl/mips_if_stage_if.sv
// Pipeline-control, program-load and IF/ID signals of the fetch stage.
interface mips_if_stage_if;

  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        pm_we_i;
  logic [9:0]  pm_addr_i;
  logic [31:0] pm_wdata_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_ir_o;
  logic [31:0] if_id_npc_o;
  logic        if_id_valid_o;
  logic        halted_o;

  modport master (
    output stall_i, redirect_i, redirect_pc_i, pm_we_i, pm_addr_i, pm_wdata_i,
    input  pc_o, if_id_ir_o, if_id_npc_o, if_id_valid_o, halted_o
  );

  modport slave (
    input  stall_i, redirect_i, redirect_pc_i, pm_we_i, pm_addr_i, pm_wdata_i,
    output pc_o, if_id_ir_o, if_id_npc_o, if_id_valid_o, halted_o
  );

endinterface

// File: rtl/mips_prog_mem.sv
// Program memory: one synchronous write port, one combinational read port.
// A read of the word being written in the same cycle returns the old contents.
module mips_prog_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_if_stage.sv
// MIPS instruction-fetch stage: word-addressed PC, program memory and the IF/ID register.
//
// state        | meaning
// ST_RUN       | normal fetch, stall and redirect handling
// ST_HALT_PEND | HLT sits in IF/ID; a redirect squashes it, otherwise fetch stops
// ST_HALTED    | fetch frozen until reset
module mips_if_stage
  import mips_pkg::*;
#(
  parameter int          PM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic            clk,
  input logic            reset,
  mips_if_stage_if.slave bus
);

  localparam int AW = (PM_DEPTH > 1) ? $clog2(PM_DEPTH) : 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [31:0]   npc_q, npc_d;
  logic          valid_q, valid_d;
  logic          halted_q;
  logic [31:0]   fetch_word;
  logic [AW-1:0] rd_idx, wr_idx;

  // Both ports wrap modulo the memory depth.
  assign rd_idx = AW'(pc_q % PM_DEPTH);
  assign wr_idx = AW'(32'(bus.pm_addr_i) % PM_DEPTH);

  mips_prog_mem #(.DEPTH(PM_DEPTH), .AW(AW)) u_prog_mem (
    .clk   (clk),
    .we    (bus.pm_we_i),
    .waddr (wr_idx),
    .wdata (bus.pm_wdata_i),
    .raddr (rd_idx),
    .rdata (fetch_word)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.redirect_i) begin
          pc_d    = bus.redirect_pc_i;
          ir_d    = NOP_WORD;
          npc_d   = 32'd0;
          valid_d = 1'b0;
        end else if (!bus.stall_i) begin
          ir_d    = fetch_word;
          npc_d   = pc_q + 32'd1;
          valid_d = 1'b1;
          // PC parks on the HLT so a squash-free halt leaves it pointing there.
          if (is_hlt(fetch_word)) state_d = ST_HALT_PEND;
          else                    pc_d    = pc_q + 32'd1;
        end
      end
      ST_HALT_PEND: begin
        if (bus.redirect_i) begin
          state_d = ST_RUN;
          pc_d    = bus.redirect_pc_i;
          ir_d    = NOP_WORD;
          npc_d   = 32'd0;
          valid_d = 1'b0;
        end else if (!bus.stall_i) begin
          state_d = ST_HALTED;
          ir_d    = NOP_WORD;
          npc_d   = 32'd0;
          valid_d = 1'b0;
        end
      end
      ST_HALTED: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      ir_q     <= NOP_WORD;
      npc_q    <= 32'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      npc_q    <= npc_d;
      valid_q  <= valid_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.if_id_ir_o    = ir_q;
  assign bus.if_id_npc_o   = npc_q;
  assign bus.if_id_valid_o = valid_q;
  assign bus.halted_o      = halted_q;

endmodule

// File: tb/tb_mips_if_stage.sv
// Scoreboard bench for mips_if_stage: directed fetch/stall/redirect/halt scenarios
// followed by randomized traffic, checked against a behavioural fetch model.
module tb_mips_if_stage;
  import mips_pkg::*;

  localparam int          PM_DEPTH = 64;
  localparam logic [31:0] RESET_PC = 32'd0;
  localparam int MODE_RUN = 0, MODE_PEND = 1, MODE_HALTED = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] npc;
    logic        valid;
    logic        halted;
  } obs_t;

  logic clk = 1'b0;
  logic reset;

  mips_if_stage_if bus();

  mips_if_stage #(.PM_DEPTH(PM_DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  obs_t sb_q[$];
  obs_t mon_e;

  logic [31:0] m_mem [PM_DEPTH];
  logic [31:0] m_pc, m_ir, m_npc;
  logic        m_valid;
  int          m_mode;
  bit          m_in_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [5:0] ops [5] = '{OP_ADD, OP_LW, OP_SW, OP_BNEQZ, OP_BEQZ};
    logic [5:0] op;
    op = ($urandom_range(0, 29) == 0) ? OP_HLT : ops[$urandom_range(0, 4)];
    return {op, 26'($urandom)};
  endfunction

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_ir    = 32'd0;
    m_npc   = 32'd0;
    m_valid = 1'b0;
    m_mode  = MODE_RUN;
  endtask

  // One clock edge of the fetch stage as described behaviourally: redirect beats stall,
  // HLT parks fetch, a halted stage ignores everything; memory write lands after the read.
  task automatic model_edge(input bit st, input bit rd, input logic [31:0] rpc,
                            input bit we, input logic [9:0] wa, input logic [31:0] wd);
    int          idx;
    logic [31:0] w;
    idx = int'(m_pc % PM_DEPTH);
    w   = m_mem[idx];
    if (!m_in_rst) begin
      if (m_mode != MODE_HALTED && rd) begin
        m_pc = rpc; m_ir = 32'd0; m_npc = 32'd0; m_valid = 1'b0; m_mode = MODE_RUN;
      end else if (m_mode == MODE_RUN && !st) begin
        m_ir = w; m_npc = m_pc + 1; m_valid = 1'b1;
        if (w[31:26] == 6'h3F) m_mode = MODE_PEND;
        else                   m_pc   = m_pc + 1;
      end else if (m_mode == MODE_PEND && !st) begin
        m_ir = 32'd0; m_npc = 32'd0; m_valid = 1'b0; m_mode = MODE_HALTED;
      end
    end
    if (we) m_mem[int'(wa) % PM_DEPTH] = wd;
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                      input bit we, input logic [9:0] wa, input logic [31:0] wd);
    obs_t e;
    bus.stall_i       = st;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    bus.pm_we_i       = we;
    bus.pm_addr_i     = wa;
    bus.pm_wdata_i    = wd;
    @(posedge clk);
    model_edge(st, rd, rpc, we, wa, wd);
    e.pc     = m_pc;
    e.ir     = m_ir;
    e.npc    = m_npc;
    e.valid  = m_valid;
    e.halted = (m_mode == MODE_HALTED);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
  endtask

  // Called just after an active edge; asserting after the falling edge keeps the
  // already-queued expectation for that edge consistent with the DUT.
  task automatic reset_assert();
    #6;
    reset = 1'b0;
    #1;
    check("rst_pc", bus.pc_o, RESET_PC);
    check("rst_ir", bus.if_id_ir_o, 32'd0);
    check("rst_npc", bus.if_id_npc_o, 32'd0);
    check("rst_valid", 32'(bus.if_id_valid_o), 32'd0);
    check("rst_halted", 32'(bus.halted_o), 32'd0);
    model_reset();
    m_in_rst = 1'b1;
  endtask

  task automatic reset_release();
    #2;
    reset    = 1'b1;
    m_in_rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("pc", bus.pc_o, mon_e.pc);
      check("ir", bus.if_id_ir_o, mon_e.ir);
      check("npc", bus.if_id_npc_o, mon_e.npc);
      check("valid", 32'(bus.if_id_valid_o), 32'(mon_e.valid));
      check("halted", 32'(bus.halted_o), 32'(mon_e.halted));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] prog [PM_DEPTH];
    int          halt_cnt;

    bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'd0;
    bus.pm_we_i = 1'b0; bus.pm_addr_i = 10'd0;  bus.pm_wdata_i = 32'd0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check("rst_pc", bus.pc_o, RESET_PC);
    check("rst_ir", bus.if_id_ir_o, 32'd0);
    check("rst_npc", bus.if_id_npc_o, 32'd0);
    check("rst_valid", 32'(bus.if_id_valid_o), 32'd0);
    check("rst_halted", 32'(bus.halted_o), 32'd0);
    model_reset();
    m_in_rst = 1'b1;

    // Preload program memory while held in reset.
    for (int i = 0; i < PM_DEPTH; i++) begin
      prog[i] = rand_word();
      if (prog[i][31:26] == OP_HLT) prog[i][31:26] = OP_ADD;
    end
    prog[0]  = 32'h2041_0000;
    prog[1]  = 32'h2083_0000;
    prog[2]  = 32'h0023_2800;
    prog[5]  = 32'hFC00_0000;
    prog[10] = 32'h24E5_0000;
    prog[11] = 32'hFC00_0000;
    for (int i = 0; i < PM_DEPTH; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 10'(i), prog[i]);
    reset_release();

    // Sequential fetch of 0..2, one-cycle load-use stall at PC 3, then on to PC 5.
    repeat (3) idle();
    step(1'b1, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
    repeat (2) idle();
    // Redirect from PC 5 to 10, then fetch 10.
    step(1'b0, 1'b1, 32'd10, 1'b0, 10'd0, 32'd0);
    idle();
    // Redirect and stall together: flush wins.
    step(1'b1, 1'b1, 32'd10, 1'b0, 10'd0, 32'd0);
    // Branch-shadow HLT at 5 squashed by a redirect to 10.
    step(1'b0, 1'b1, 32'd5, 1'b0, 10'd0, 32'd0);
    idle();
    step(1'b0, 1'b1, 32'd10, 1'b0, 10'd0, 32'd0);
    idle();
    // Real HLT at 11, then redirect/stall pulses that must be ignored.
    repeat (2) idle();
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
           1'b0, 10'd0, 32'd0);
    reset_assert();
    idle();
    reset_release();

    // Randomized traffic with memory rewrites, reset between rounds and after long halts.
    for (int r = 0; r < 4; r++) begin
      halt_cnt = 0;
      for (int c = 0; c < 200; c++) begin
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), 32'($urandom_range(0, 127)),
             ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 1) == 0) ? m_pc[9:0] : 10'($urandom),
             rand_word());
        if (m_mode == MODE_HALTED) halt_cnt++;
        if (halt_cnt > 8) begin
          halt_cnt = 0;
          reset_assert();
          for (int k = 0; k < 4; k++)
            step(1'b0, 1'b0, 32'd0, 1'b1, 10'($urandom), rand_word());
          reset_release();
        end
      end
      reset_assert();
      for (int k = 0; k < 8; k++)
        step(1'b0, 1'b0, 32'd0, 1'b1, 10'($urandom), rand_word());
      reset_release();
    end

    repeat (5) begin
      if (sb_q.size() > 0) @(negedge clk);
    end
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
